// File: rtl/switch_led_ctrl.sv
// Per-channel switch synchroniser, counter debouncer and LED driver with follow/toggle modes and rise/fall pulses.
// Optional blink feature enabled by defining SWLED_BLINK_EN (adds blink_mask input).
module switch_led_ctrl #(
  parameter int CH          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int BLINK_HALF  = 25000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] sw,
  input  logic          mode,
`ifdef SWLED_BLINK_EN
  input  logic [CH-1:0] blink_mask,
`endif
  output logic [CH-1:0] led,
  output logic [CH-1:0] sw_db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (CH < 1 || SYNC_STAGES < 2 || DB_CYCLES < 1 || BLINK_HALF < 1) begin : g_param_check
    $error("switch_led_ctrl: illegal parameter value");
  end

  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] s;
  logic [CW-1:0] cnt      [CH];
  logic [CW-1:0] cnt_next [CH];
  logic [CH-1:0] db_next;
  logic [CH-1:0] tog;
  logic [CH-1:0] rise_next;
  logic [CH-1:0] sel;
  logic [CH-1:0] led_next;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  // A level is accepted only after DB_CYCLES consecutive clocks disagreeing with sw_db.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      cnt_next[i] = '0;
      db_next[i]  = sw_db[i];
      if (s[i] != sw_db[i]) begin
        if (cnt[i] == CNT_LAST) db_next[i] = s[i];
        else                    cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  assign rise_next = db_next & ~sw_db;
  assign sel       = mode ? tog : db_next;

`ifdef SWLED_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  // Masked channels that would be lit follow the blink phase instead.
  assign led_next = sel & (~blink_mask | {CH{blink_phase}});
`else
  assign led_next = sel;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
      sw_db <= '0;
      tog   <= '0;
      led   <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      for (int i = 0; i < CH; i++) cnt[i] <= cnt_next[i];
      sw_db <= db_next;
      tog   <= tog ^ rise_next;
      led   <= led_next;
      rise  <= rise_next;
      fall  <= ~db_next & sw_db;
    end
  end

endmodule

// File: tb/tb_switch_led_ctrl.sv
// Directed self-checking bench for switch_led_ctrl (CH=4, SYNC_STAGES=2, DB_CYCLES=4, BLINK_HALF=3).
module tb_switch_led_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       mode;
  logic [3:0] led, sw_db, rise, fall;
`ifdef SWLED_BLINK_EN
  logic [3:0] blink_mask;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  switch_led_ctrl #(
    .CH(4), .SYNC_STAGES(2), .DB_CYCLES(4), .BLINK_HALF(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .mode(mode),
`ifdef SWLED_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .led(led),
    .sw_db(sw_db),
    .rise(rise),
    .fall(fall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // One press/release of sw[2] in toggle mode; exp is the led[2] level after the press.
  task automatic press_release(input logic exp);
    sw = 4'b0100;
    ticks(6);
    check("tog_rise", rise, 4'b0100);
    check("tog_led_lag", led, exp ? 4'b0000 : 4'b0100);
    tick();
    check("tog_led", led, exp ? 4'b0100 : 4'b0000);
    sw = 4'b0000;
    ticks(6);
    check("tog_fall", fall, 4'b0100);
    tick();
    check("tog_fall_no_effect", led, exp ? 4'b0100 : 4'b0000);
  endtask

  logic bad;
  int   ones;

  initial begin
    rst_n = 1'b0;
    sw    = 4'hF;
    mode  = 1'b0;
`ifdef SWLED_BLINK_EN
    blink_mask = 4'b0000;
`endif

    // Reset held with switches high
    ticks(3);
    check("rst_led", led, 4'h0);
    check("rst_sw_db", sw_db, 4'h0);
    check("rst_rise", rise, 4'h0);
    check("rst_fall", fall, 4'h0);
    rst_n = 1'b1;
    ticks(5);
    check("rel_sw_db_early", sw_db, 4'h0);
    check("rel_rise_early", rise, 4'h0);
    tick();
    check("rel_sw_db", sw_db, 4'hF);
    check("rel_rise", rise, 4'hF);
    check("rel_led", led, 4'hF);
    tick();
    check("rel_rise_drop", rise, 4'h0);

    // All switches low again
    sw = 4'h0;
    ticks(5);
    check("all_fall_early", fall, 4'h0);
    tick();
    check("all_fall", fall, 4'hF);
    check("all_low_led", led, 4'h0);
    tick();
    check("all_fall_drop", fall, 4'h0);

    // Follow mode, clean edge on sw[0]
    sw = 4'b0001;
    ticks(5);
    check("f0_rise_early", rise, 4'h0);
    check("f0_led_early", led, 4'h0);
    tick();
    check("f0_rise", rise, 4'b0001);
    check("f0_led", led, 4'b0001);
    tick();
    check("f0_rise_drop", rise, 4'h0);
    check("f0_led_hold", led, 4'b0001);
    sw = 4'b0000;
    ticks(6);
    check("f0_fall", fall, 4'b0001);
    check("f0_led_off", led, 4'h0);
    tick();

    // Bounce on sw[1]: stretches of 2 clocks must be rejected
    bad = 1'b0;
    for (int b = 0; b < 4; b++) begin
      sw = (b % 2 == 0) ? 4'b0010 : 4'b0000;
      repeat (2) begin
        tick();
        if ((rise | fall) != 4'h0) bad = 1'b1;
      end
    end
    sw = 4'b0010;
    repeat (5) begin
      tick();
      if ((rise | fall) != 4'h0) bad = 1'b1;
    end
    check("bounce_no_pulse", bad, 1'b0);
    tick();
    check("bounce_rise", rise, 4'b0010);
    check("bounce_sw_db", sw_db, 4'b0010);

    // Fresh reset with switches low so toggle state starts at 0
    sw = 4'h0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    ticks(2);
    check("rst2_sw_db", sw_db, 4'h0);
    mode = 1'b1;
    tick();
    check("tog_led_init", led, 4'h0);

    press_release(1'b1);
    press_release(1'b0);
    press_release(1'b1);

    mode = 1'b0;
    tick();
    check("mode_follow_led", led, 4'h0);

    // Reset in the middle of a debounce count
    sw = 4'b1000;
    ticks(4);
    rst_n = 1'b0;
    tick();
    check("mid_rst_sw_db", sw_db, 4'h0);
    check("mid_rst_led", led, 4'h0);
    rst_n = 1'b1;
    ticks(5);
    check("mid_sw_db_early", sw_db, 4'h0);
    tick();
    check("mid_sw_db", sw_db, 4'b1000);
    check("mid_rise", rise, 4'b1000);
    check("mid_led", led, 4'b1000);

`ifdef SWLED_BLINK_EN
    blink_mask = 4'b0001;
    sw = 4'b1001;
    ticks(8);
    ones = 0;
    bad  = 1'b0;
    repeat (12) begin
      tick();
      if (led[0]) ones++;
      if (led[3] !== 1'b1 || led[2:1] !== 2'b00) bad = 1'b1;
    end
    check("blink_duty", ones, 6);
    check("blink_others", bad, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_led_ctrl.md
Name: switch_led_ctrl

Overview:
- Parametrised, clocked successor to the direct switch-to-LED path for the Basys 3 board (100 MHz).
- Per channel: synchronises each slide switch, debounces it with a counter, and drives the matching LED.
- Two LED modes: follow (LED = debounced switch) and toggle (LED flips on each debounced rising edge).
- Also emits one-cycle rise/fall event pulses for downstream logic.

Parameters:
- CH, 16, number of switch/LED channels (1..16 on Basys 3).
- SYNC_STAGES, 2, flip-flop synchroniser depth per channel (min 2).
- DB_CYCLES, 1000000, consecutive stable clocks needed to accept a new switch level (10 ms at 100 MHz); min 1.
- BLINK_HALF, 25000000, half-period of the blink square wave in clocks (optional feature only).

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- sw  in  CH  raw asynchronous slide switches.
- mode  in  1  0 = follow, 1 = toggle; global, sampled every clock.
- led  out  CH  registered LED drive.
- sw_db  out  CH  debounced switch level.
- rise  out  CH  one-clock pulse when sw_db goes 0->1.
- fall  out  CH  one-clock pulse when sw_db goes 1->0.

Behaviour:
- Reset (rst_n=0 at a rising edge) clears the following to 0: synchroniser flops, debounce counters, sw_db, toggle state, led, rise, fall. Reset mid-count discards the count.
- Sync: sw[i] passes through SYNC_STAGES flops to give s[i].
- Debounce counter cnt[i], width clog2(DB_CYCLES+1):
  - s[i]==sw_db[i]: cnt <= 0.
  - s[i]!=sw_db[i] and cnt<DB_CYCLES-1: cnt <= cnt+1.
  - s[i]!=sw_db[i] and cnt==DB_CYCLES-1: sw_db[i] <= s[i], cnt <= 0, and the matching rise[i]/fall[i] is asserted for exactly that next cycle.
- Latency: a clean sw edge reaches sw_db, rise/fall and led (follow mode) L = SYNC_STAGES + DB_CYCLES clocks after the first clock edge that samples it.
- Glitch rejection: any bounce shorter than DB_CYCLES clocks (after sync) resets cnt and never changes sw_db.
- Toggle state tog[i]: flips on the same edge that sets rise[i]; fall has no effect. tog updates in both modes.
- LED output: registered, led[i] <= mode ? tog[i] : sw_db_next[i], so in follow mode led changes on the same edge as sw_db.
- Mode change: takes effect on the next edge; tog is not modified by a mode change.
- Switch held high through reset release: sw_db rises L clocks after release, generating a rise pulse and a tog flip. This is required behaviour.
- Channels are fully independent; simultaneous events on several channels are all honoured in the same cycle.

Optional Feature:
- Macro SWLED_BLINK_EN.
- Defined:
  - Adds input blink_mask (CH bits).
  - Adds a free-running counter that inverts a blink phase every BLINK_HALF clocks; the phase resets to 0 (LED dark) with rst_n.
  - A channel with blink_mask[i]=1 whose selected LED value is 1 drives led[i] = blink phase.
  - Mask=0 or selected value 0 behaves as without the feature.
- Not defined: no blink_mask port, no blink counter; led is exactly as in Behaviour.

Test Plan (CH=4, SYNC_STAGES=2, DB_CYCLES=4, BLINK_HALF=3):
- Reset: hold rst_n=0 for 3 clocks with sw=4'hF -> led, sw_db, rise, fall all 0. After release, sw_db=4'hF at clock 6, rise=4'hF for 1 clock.
- Follow mode, clean edge: sw[0] 0->1 -> led[0]=1 and rise[0]=1 exactly 6 clocks later. rise[0] drops the next clock. sw[0] 1->0 -> fall[0] pulse 6 clocks later.
- Bounce: sw[1] toggles 1,0,1,0 every 2 clocks, then settles at 1 -> no pulses during bouncing; single rise[1] 6 clocks after final settle.
- Toggle mode: mode=1, three clean press/release cycles on sw[2] -> led[2] sequence 1,0,1. fall pulses do not change led. Switching to mode=0 shows sw_db[2] next clock.
- Reset mid-count: sw[3] 0->1, rst_n=0 at count 2 for 1 clock -> sw_db[3] stays 0 through reset and rises 6 clocks after release.
- SWLED_BLINK_EN: blink_mask=4'b0001, sw[0] high in follow mode -> led[0] alternates 3 clocks on / 3 clocks off. led[1..3] unaffected.
